// File: rtl/vanilla_saif_window_ctrl.sv
// Global SAIF enable controller: merges per-tile dumper requests into one
// registered enable, tracks recording windows and enforces a window limit.
module vanilla_saif_window_ctrl #(
   parameter  int num_tiles_p         = 16,
   parameter  int cycle_count_width_p = 32,
   parameter  int max_windows_p       = 1,
   localparam int tile_cnt_width_lp   = $clog2(num_tiles_p + 1)
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic [num_tiles_p-1:0]         saif_en_i,
   output logic                           saif_en_o,
   output logic                           toggle_start_o,
   output logic                           toggle_stop_o,
   output logic                           done_o,
   output logic [tile_cnt_width_lp-1:0]   active_tiles_o,
   output logic [15:0]                    window_count_o,
   output logic [cycle_count_width_p-1:0] enabled_cycles_o,
   output logic                           overlap_err_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_e;

   state_e                 state_r;
   state_e                 state_next_s;
   logic [num_tiles_p-1:0] req_r;
   logic [num_tiles_p-1:0] req_d_r;
   logic                   any_req_s;
   logic                   start_s;
   logic                   stop_s;
   logic                   limit_hit_s;
   logic [15:0]            window_next_s;

   function automatic logic [tile_cnt_width_lp-1:0] popcount(input logic [num_tiles_p-1:0] v);
      logic [tile_cnt_width_lp-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < num_tiles_p; i++) begin
         cnt = cnt + tile_cnt_width_lp'(v[i]);
      end
      return cnt;
   endfunction

   assign any_req_s     = |req_r;
   assign window_next_s = window_count_o + 16'd1;
   assign limit_hit_s   = (max_windows_p != 0) && (window_next_s == 16'(max_windows_p));

   // Window state machine: next state and pulse requests
   always_comb begin
      state_next_s = state_r;
      start_s      = 1'b0;
      stop_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_next_s = ACTIVE;
               start_s      = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         ACTIVE: begin
            if (!any_req_s) begin
               stop_s = 1'b1;
               if (limit_hit_s) begin
                  state_next_s = DONE;
               end else begin
                  state_next_s = IDLE;
               end
            end else begin
               state_next_s = ACTIVE;
            end
         end
         DONE: begin
            state_next_s = DONE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Input stage; popcount is taken from the same sample so it always matches req_r
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         req_r          <= '0;
         req_d_r        <= '0;
         active_tiles_o <= '0;
      end else begin
         req_r          <= saif_en_i;
         req_d_r        <= req_r;
         active_tiles_o <= popcount(saif_en_i);
      end
   end

   // State and registered control outputs, derived from the next state
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r        <= IDLE;
         saif_en_o      <= 1'b0;
         toggle_start_o <= 1'b0;
         toggle_stop_o  <= 1'b0;
         done_o         <= 1'b0;
      end else begin
         state_r        <= state_next_s;
         saif_en_o      <= (state_next_s == ACTIVE);
         toggle_start_o <= start_s;
         toggle_stop_o  <= stop_s;
         done_o         <= (state_next_s == DONE);
      end
   end

   // Window / enabled-cycle counters and sticky overlap flag
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         window_count_o   <= 16'd0;
         enabled_cycles_o <= '0;
         overlap_err_o    <= 1'b0;
      end else begin
         if (stop_s) begin
            window_count_o <= window_next_s;
         end
         if ((state_r == ACTIVE) && !(&enabled_cycles_o)) begin
            enabled_cycles_o <= enabled_cycles_o + cycle_count_width_p'(1);
         end
         if ((state_r == ACTIVE) && (|(req_r & ~req_d_r))) begin
            overlap_err_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vanilla_saif_window_ctrl.sv
// Bench for vanilla_saif_window_ctrl: scoreboarded start/stop pulses plus
// directed status checks on a default instance and an unlimited 4-bit-counter instance.
module tb_vanilla_saif_window_ctrl;

   logic        clk = 1'b0;
   int          cyc = 0;
   int          n_pass = 0;
   int          n_total = 0;

   logic        rst_a, rst_b;
   logic [15:0] en_a, en_b;

   logic        sen_a, start_a, stop_a, done_a, ovl_a;
   logic [4:0]  tiles_a;
   logic [15:0] wc_a;
   logic [31:0] ec_a;

   logic        sen_b, start_b, stop_b, done_b, ovl_b;
   logic [4:0]  tiles_b;
   logic [15:0] wc_b;
   logic [3:0]  ec_b;

   // expected pulse record: {kind(0=start,1=stop), cycle}
   logic [32:0] q_a[$];
   logic [32:0] q_b[$];

   vanilla_saif_window_ctrl #(.num_tiles_p(16), .cycle_count_width_p(32), .max_windows_p(1)) dut_a (
      .clk_i(clk), .reset_n_i(rst_a), .saif_en_i(en_a),
      .saif_en_o(sen_a), .toggle_start_o(start_a), .toggle_stop_o(stop_a),
      .done_o(done_a), .active_tiles_o(tiles_a), .window_count_o(wc_a),
      .enabled_cycles_o(ec_a), .overlap_err_o(ovl_a));

   vanilla_saif_window_ctrl #(.num_tiles_p(16), .cycle_count_width_p(4), .max_windows_p(0)) dut_b (
      .clk_i(clk), .reset_n_i(rst_b), .saif_en_i(en_b),
      .saif_en_o(sen_b), .toggle_start_o(start_b), .toggle_stop_o(stop_b),
      .done_o(done_b), .active_tiles_o(tiles_b), .window_count_o(wc_b),
      .enabled_cycles_o(ec_b), .overlap_err_o(ovl_b));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every pulse from a DUT must match the oldest queued expectation
   always @(negedge clk) begin
      logic [32:0] got;
      logic [32:0] exp;
      if (start_a || stop_a) begin
         got = {stop_a, 32'(cyc)};
         if (start_a && stop_a) check("a_both_pulses", 32'd1, 32'd0);
         else if (q_a.size() == 0) check("a_unexpected_pulse", got[31:0], 32'd0);
         else begin
            exp = q_a.pop_front();
            check(exp[32] ? "a_stop_cycle" : "a_start_cycle", got[31:0], exp[31:0]);
            check("a_pulse_kind", {31'd0, got[32]}, {31'd0, exp[32]});
         end
      end
      if (start_b || stop_b) begin
         got = {stop_b, 32'(cyc)};
         if (start_b && stop_b) check("b_both_pulses", 32'd1, 32'd0);
         else if (q_b.size() == 0) check("b_unexpected_pulse", got[31:0], 32'd0);
         else begin
            exp = q_b.pop_front();
            check(exp[32] ? "b_stop_cycle" : "b_start_cycle", got[31:0], exp[31:0]);
            check("b_pulse_kind", {31'd0, got[32]}, {31'd0, exp[32]});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      en_a  = 16'd0;
      en_b  = 16'd0;

      wait_cyc(2);
      check("rst_saif_en", {31'd0, sen_a}, 32'd0);
      check("rst_done", {31'd0, done_a}, 32'd0);
      check("rst_wc", {16'd0, wc_a}, 32'd0);
      check("rst_ec", ec_a, 32'd0);
      check("rst_tiles", {27'd0, tiles_a}, 32'd0);
      check("rst_b_ec", {28'd0, ec_b}, 32'd0);
      wait_cyc(3);
      rst_a = 1'b1;
      rst_b = 1'b1;

      // A: single window under default limit; B: unlimited windows
      wait_cyc(10);
      en_a = 16'h0008; q_a.push_back({1'b0, 32'd12});
      en_b = 16'h0001; q_b.push_back({1'b0, 32'd12});
      wait_cyc(15);
      en_b = 16'h0000; q_b.push_back({1'b1, 32'd17});
      wait_cyc(20);
      check("a_saif_en_mid", {31'd0, sen_a}, 32'd1);
      en_b = 16'h0001; q_b.push_back({1'b0, 32'd22});
      wait_cyc(27);
      en_b = 16'h0000; q_b.push_back({1'b1, 32'd29});
      wait_cyc(30);
      en_a = 16'h0000; q_a.push_back({1'b1, 32'd32});
      check("b_ec_two_windows", {28'd0, ec_b}, 32'd12);
      check("b_wc_two_windows", {16'd0, wc_b}, 32'd2);
      check("b_done_unlimited", {31'd0, done_b}, 32'd0);
      wait_cyc(32);
      check("a_done_at_stop", {31'd0, done_a}, 32'd1);
      wait_cyc(33);
      check("a_saif_en_closed", {31'd0, sen_a}, 32'd0);
      check("a_ec_20", ec_a, 32'd20);
      check("a_wc_1", {16'd0, wc_a}, 32'd1);

      // A locked: tile 7 must be ignored; B: 20-cycle window saturates 4-bit counter
      wait_cyc(35);
      en_b = 16'h0001; q_b.push_back({1'b0, 32'd37});
      wait_cyc(40);
      en_a = 16'h0080;
      wait_cyc(45);
      check("a_locked_saif_en", {31'd0, sen_a}, 32'd0);
      wait_cyc(50);
      en_a = 16'h0000;
      wait_cyc(52);
      check("a_locked_wc", {16'd0, wc_a}, 32'd1);
      check("a_locked_ec", ec_a, 32'd20);
      check("a_locked_done", {31'd0, done_a}, 32'd1);
      wait_cyc(55);
      en_b = 16'h0000; q_b.push_back({1'b1, 32'd57});
      wait_cyc(58);
      check("b_ec_saturated", {28'd0, ec_b}, 32'd15);
      check("b_wc_3", {16'd0, wc_b}, 32'd3);
      check("b_saif_en_closed", {31'd0, sen_b}, 32'd0);

      // A: overlapping requests give one window and the overlap flag
      wait_cyc(60);
      rst_a = 1'b0;
      wait_cyc(62);
      rst_a = 1'b1;
      wait_cyc(70);
      en_a = 16'h0001; q_a.push_back({1'b0, 32'd72});
      wait_cyc(72);
      check("ovl_tiles_1", {27'd0, tiles_a}, 32'd1);
      check("ovl_flag_clear", {31'd0, ovl_a}, 32'd0);
      wait_cyc(74);
      en_a = 16'h0021;
      wait_cyc(76);
      check("ovl_tiles_2", {27'd0, tiles_a}, 32'd2);
      wait_cyc(77);
      check("ovl_flag_set", {31'd0, ovl_a}, 32'd1);
      wait_cyc(80);
      en_a = 16'h0020;
      wait_cyc(81);
      check("ovl_saif_en_held", {31'd0, sen_a}, 32'd1);
      wait_cyc(82);
      check("ovl_tiles_back_1", {27'd0, tiles_a}, 32'd1);
      wait_cyc(86);
      en_a = 16'h0000; q_a.push_back({1'b1, 32'd88});
      wait_cyc(89);
      check("ovl_ec_16", ec_a, 32'd16);
      check("ovl_wc_1", {16'd0, wc_a}, 32'd1);

      // A: tile 1 falls as tile 2 rises -> window stays open
      wait_cyc(95);
      rst_a = 1'b0;
      wait_cyc(96);
      check("rst_clears_overlap", {31'd0, ovl_a}, 32'd0);
      wait_cyc(97);
      rst_a = 1'b1;
      wait_cyc(100);
      en_a = 16'h0002; q_a.push_back({1'b0, 32'd102});
      wait_cyc(106);
      en_a = 16'h0004;
      wait_cyc(108);
      check("swap_saif_en_held", {31'd0, sen_a}, 32'd1);
      wait_cyc(112);
      en_a = 16'h0000; q_a.push_back({1'b1, 32'd114});
      wait_cyc(115);
      check("swap_wc_1", {16'd0, wc_a}, 32'd1);

      // A: asynchronous reset mid-window, then a fresh window
      wait_cyc(116);
      rst_a = 1'b0;
      wait_cyc(118);
      rst_a = 1'b1;
      wait_cyc(120);
      en_a = 16'h0010; q_a.push_back({1'b0, 32'd122});
      wait_cyc(130);
      #3;
      rst_a = 1'b0;
      #1;
      check("async_rst_saif_en", {31'd0, sen_a}, 32'd0);
      check("async_rst_ec", ec_a, 32'd0);
      check("async_rst_tiles", {27'd0, tiles_a}, 32'd0);
      check("async_rst_pulses", {30'd0, start_a, stop_a}, 32'd0);
      wait_cyc(134);
      rst_a = 1'b1; q_a.push_back({1'b0, 32'd136});
      wait_cyc(137);
      check("post_rst_saif_en", {31'd0, sen_a}, 32'd1);
      check("post_rst_wc_0", {16'd0, wc_a}, 32'd0);
      wait_cyc(140);
      en_a = 16'h0000; q_a.push_back({1'b1, 32'd142});
      wait_cyc(143);
      check("post_rst_wc_1", {16'd0, wc_a}, 32'd1);
      check("post_rst_done", {31'd0, done_a}, 32'd1);

      wait_cyc(150);
      check("a_queue_drained", 32'(q_a.size()), 32'd0);
      check("b_queue_drained", 32'(q_b.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
